tick_stopwatch: RTL
===================

Name: tick_stopwatch

Overview:
- Consumer end of the master clock divider's slow square-wave outputs (1 Hz and 32 Hz).
- Synchronises both inputs into the clk domain and turns their rising edges into one-cycle ticks.
- Drives an MM:SS BCD stopwatch with pause, clear and per-field adjust mode.
- Outputs feed the seven-segment display driver.

Parameters:
- MAX_MIN_TENS, 5, tens digit of minutes at wrap point (count wraps after MAX_MIN_TENS9:59)
- ADJ_DIV, 16, number of 32 Hz ticks per adjust increment (16 gives 2 Hz)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- one_hz_in  in  1  1 Hz square wave from divider; asynchronous to clk by assumption of no phase relation
- fast_in  in  1  32 Hz square wave from divider
- pause_pulse  in  1  one-cycle, debounced; toggles run/pause
- clear  in  1  level; zeroes count while high
- adj_en  in  1  level; 1 = adjust mode
- sel  in  1  adjust field: 0 = seconds, 1 = minutes
- min_tens  out  4  BCD 0..MAX_MIN_TENS
- min_ones  out  4  BCD 0..9
- sec_tens  out  4  BCD 0..5
- sec_ones  out  4  BCD 0..9
- running  out  1  1 = counting
- blink  out  1  adjust-mode blank flag for the selected field

Behaviour:
- Reset (async, rst=1):
  - all digits = 0; running = 0; blink = 0; prescaler = 0.
  - Sync flops = 0; edge-history flops = 1, so an input already high at release produces no tick.
- Synchroniser, per input: 2-flop sync, then history flop.
  - tick = sync2 & ~hist.
  - An input rising edge that meets setup produces a one-cycle tick on the 3rd clk edge.
  - The counter update is visible at the 3rd clk edge.
- Prescaler:
  - Counts tick_fast from 0 to ADJ_DIV-1, then wraps.
  - adj_tick = tick_fast when prescaler == ADJ_DIV-1.
  - Free-running in all modes.
- Run/pause: pause_pulse toggles running in every mode.
- Priority each cycle: clear > adjust > run.
- clear = 1:
  - All digits go to 0 next edge; running is unchanged.
  - Ticks in that cycle are discarded.
- Adjust mode (adj_en = 1):
  - tick_1 is ignored.
  - On adj_tick, the selected field increments by 1 with no carry into the other field.
  - Seconds field wraps 59→00.
  - Minutes field wraps MAX_MIN_TENS9→00.
  - blink toggles on each adj_tick.
  - blink is forced to 0 when adj_en = 0.
- Run mode (adj_en = 0, running = 1): on tick_1, increment with full BCD carry:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_ones.
  - min_ones 9→0 carries into min_tens.
  - At MAX_MIN_TENS9:59 the whole count wraps to 00:00.
- Paused (running = 0, adj_en = 0): digits hold.
- Simultaneous events:
  - pause_pulse together with tick_1: the tick uses the pre-toggle value of running.
  - tick_1 and adj_tick together in adjust mode: only adj_tick acts.
- Digits never leave their legal BCD range; no illegal encodings are reachable.
- rst asserted mid-count returns everything to reset values immediately, without waiting for a clk edge.

Decomposition:
- Shared package:
  - BCD_MAX_ONES = 9
  - SEC_TENS_MAX = 5
  - field-select encodings SEL_SEC = 0, SEL_MIN = 1
  - a 4-bit bcd_digit typedef
- Sub-module tick_sync_edge: 2-flop synchroniser plus rising-edge detect. Instantiated twice.
- BCD counter chain and prescaler stay in the top.

Test Plan:
- Reset release with one_hz_in already high, running set by pause_pulse → no increment until the next low→high transition; the first rising edge gives 00:01 on the 3rd clk edge.
- Running from 00:58, two 1 Hz rising edges → 00:59, then 01:00.
- Wrap (default params): load 59:59 via adjust, exit adjust, run one tick → 00:00, running still 1.
- Adjust: adj_en = 1, sel = 0, seconds = 58, 48 fast_in rising edges → seconds 59, 00, 01; minutes unchanged; blink toggles 3 times; one_hz_in edges ignored.
- Pause: running at 00:10, pause_pulse, 5 one_hz edges → holds 00:10; second pause_pulse then 1 edge → 00:11.
- clear asserted in the same cycle as tick_1 at 12:34 → 00:00 next edge, running unchanged; async rst mid-count → all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/tick_stopwatch_pkg.sv
// Shared types, constants and BCD helpers for the tick-driven MM:SS stopwatch.
package tick_stopwatch_pkg;

    typedef logic [3:0] bcd_digit;

    localparam bcd_digit BCD_MAX_ONES = 4'd9;
    localparam bcd_digit SEC_TENS_MAX = 4'd5;

    localparam logic SEL_SEC = 1'b0;
    localparam logic SEL_MIN = 1'b1;

    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_CLEAR,
        MODE_ADJUST,
        MODE_RUN
    } mode_t;

    typedef enum logic {
        ST_PAUSED,
        ST_RUNNING
    } run_state_t;

    typedef struct packed {
        bcd_digit tens;
        bcd_digit ones;
    } bcd_pair_t;

    // The >= compare folds any out-of-range value back to zero, so a digit
    // can never escape its legal range.
    function automatic bcd_digit bcd_wrap_inc(bcd_digit d, bcd_digit max);
        return (d >= max) ? '0 : d + 4'd1;
    endfunction

    function automatic logic bcd_pair_at_max(bcd_pair_t p, bcd_digit tens_max);
        return (p.ones >= BCD_MAX_ONES) && (p.tens >= tens_max);
    endfunction

    function automatic bcd_pair_t bcd_pair_inc(bcd_pair_t p, bcd_digit tens_max);
        bcd_pair_t r;
        r.ones = bcd_wrap_inc(p.ones, BCD_MAX_ONES);
        r.tens = (p.ones >= BCD_MAX_ONES) ? bcd_wrap_inc(p.tens, tens_max) : p.tens;
        return r;
    endfunction

endpackage

// File: rtl/tick_stopwatch_sync.sv
// Two-flop synchroniser plus rising-edge detector producing a one-cycle tick.
module tick_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic wave,
    output logic tick
);

    logic       sync_p0;
    logic       sync_p1;
    logic       hist_p2;
    logic [1:0] warm;

    // History stays at 1 until the sync chain has refilled after reset, so a
    // wave that is already high at release is never mistaken for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b1;
            warm    <= 2'b00;
        end else begin
            sync_p0 <= wave;
            sync_p1 <= sync_p0;
            warm    <= {warm[0], 1'b1};
            if (warm[1]) begin
                hist_p2 <= sync_p1;
            end
        end
    end

    assign tick = sync_p1 & ~hist_p2;

endmodule

// File: rtl/tick_stopwatch.sv
// MM:SS BCD stopwatch clocked by synchronised 1 Hz / 32 Hz divider outputs,
// with run/pause, clear and per-field adjust.
module tick_stopwatch
    import tick_stopwatch_pkg::*;
#(
    parameter int MAX_MIN_TENS = 5,
    parameter int ADJ_DIV      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_hz_in,
    input  logic       fast_in,
    input  logic       pause_pulse,
    input  logic       clear,
    input  logic       adj_en,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       blink
);

    localparam int             PRE_W        = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(ADJ_DIV - 1);
    localparam bcd_digit       MIN_TENS_MAX = bcd_digit'(MAX_MIN_TENS);

    logic             tick_1;
    logic             tick_fast;
    logic             adj_tick;
    logic [PRE_W-1:0] prescale;

    run_state_t run_state;
    run_state_t run_state_nxt;
    mode_t      mode;

    bcd_pair_t sec_cnt;
    bcd_pair_t min_cnt;
    bcd_pair_t sec_nxt;
    bcd_pair_t min_nxt;

    tick_sync_edge u_sync_1hz (
        .clk  (clk),
        .rst  (rst),
        .wave (one_hz_in),
        .tick (tick_1)
    );

    tick_sync_edge u_sync_fast (
        .clk  (clk),
        .rst  (rst),
        .wave (fast_in),
        .tick (tick_fast)
    );

    assign adj_tick = tick_fast && (prescale == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_state <= ST_PAUSED;
        end else begin
            run_state <= run_state_nxt;
        end
    end

    // The count update below reads run_state, so a tick arriving with
    // pause_pulse still uses the pre-toggle running value.
    always_comb begin
        run_state_nxt = run_state;
        if (pause_pulse) begin
            run_state_nxt = (run_state == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
        end
    end

    assign running = (run_state == ST_RUNNING);

    always_comb begin
        mode = MODE_HOLD;
        if (clear) begin
            mode = MODE_CLEAR;
        end else if (adj_en) begin
            mode = MODE_ADJUST;
        end else if (running) begin
            mode = MODE_RUN;
        end
    end

    always_comb begin
        sec_nxt = sec_cnt;
        min_nxt = min_cnt;
        case (mode)
            MODE_CLEAR: begin
                sec_nxt = '0;
                min_nxt = '0;
            end
            MODE_ADJUST: begin
                if (adj_tick) begin
                    case (sel)
                        SEL_SEC: sec_nxt = bcd_pair_inc(sec_cnt, SEC_TENS_MAX);
                        SEL_MIN: min_nxt = bcd_pair_inc(min_cnt, MIN_TENS_MAX);
                        default: ;
                    endcase
                end
            end
            MODE_RUN: begin
                if (tick_1) begin
                    sec_nxt = bcd_pair_inc(sec_cnt, SEC_TENS_MAX);
                    if (bcd_pair_at_max(sec_cnt, SEC_TENS_MAX)) begin
                        min_nxt = bcd_pair_inc(min_cnt, MIN_TENS_MAX);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_cnt  <= '0;
            min_cnt  <= '0;
            prescale <= '0;
            blink    <= 1'b0;
        end else begin
            sec_cnt <= sec_nxt;
            min_cnt <= min_nxt;
            if (tick_fast) begin
                prescale <= (prescale == PRE_LAST) ? '0 : prescale + 1'b1;
            end
            blink <= adj_en ? (blink ^ adj_tick) : 1'b0;
        end
    end

    assign min_tens = min_cnt.tens;
    assign min_ones = min_cnt.ones;
    assign sec_tens = sec_cnt.tens;
    assign sec_ones = sec_cnt.ones;

endmodule
